programma_lader: RTL

Serial program loader that receives 40-bit instruction words over a UART line and writes them into the processor's instruction memory. It is the writer for the instruction fetch path: the processor reads `{insIdentifier, argument1, argument2}` words by `pc`, and this block fills those words at consecutive addresses from 0. While a load is in progress it holds the processor halted, then releases it with a one-cycle `laden_klaar` pulse.

---
 rtl/lader_pkg.sv | 38 +++
 rtl/programma_lader_if.sv | 18 +
 rtl/uart_rx_byte.sv | 108 ++++++++++
 rtl/programma_lader.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/lader_pkg.sv
// -----------------------------------------------------------------------------
// lader_pkg
// Shared definitions for the serial program loader and the instruction fetch
// path: default frame header, instruction word geometry, and the state
// encodings of the loader FSM and the UART byte receiver.
// -----------------------------------------------------------------------------
package lader_pkg;

  localparam logic [7:0] HEADER_BYTE_DEFAULT = 8'hA5;

  // One instruction word: {identifier[7:0], argument1[15:0], argument2[15:0]}.
  localparam int WORD_BYTES = 5;
  localparam int WORD_W     = 8 * WORD_BYTES;

  typedef logic [WORD_W-1:0] instr_word_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_COUNT,
    ST_DATA,
    ST_WRITE,
    ST_CHECK,
    ST_DONE
  } lader_state_e;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_e;

  // A count byte of zero stands for a full 256-word program.
  function automatic logic [8:0] words_in_frame(input logic [7:0] n);
    return (n == 8'd0) ? 9'd256 : {1'b0, n};
  endfunction

endpackage

// File: rtl/programma_lader_if.sv
// -----------------------------------------------------------------------------
// programma_lader_if
// Write port into the instruction memory.
//   mem_we    : one-cycle write strobe
//   mem_addr  : 16-bit word address
//   mem_wdata : 40-bit instruction word
// Modports: master = loader (drives), slave = instruction memory (receives).
// -----------------------------------------------------------------------------
interface programma_lader_if;
  import lader_pkg::*;

  logic        mem_we;
  logic [15:0] mem_addr;
  instr_word_t mem_wdata;

  modport master (output mem_we, output mem_addr, output mem_wdata);
  modport slave  (input  mem_we, input  mem_addr, input  mem_wdata);
endinterface

// File: rtl/uart_rx_byte.sv
// -----------------------------------------------------------------------------
// uart_rx_byte
// 8N1 UART receiver, LSB first, for an rx line asynchronous to clock.
//   clock, reset_n : system clock, asynchronous active-low reset
//   rx             : raw receive line, idle high
//   byte_valid     : one-cycle strobe, one cycle after a good stop-bit sample
//   byte_data      : received byte, valid with byte_valid
//   frame_err      : one-cycle strobe when the stop bit is sampled low
// -----------------------------------------------------------------------------
module uart_rx_byte
  import lader_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       rx,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       frame_err
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);

  // [0],[1] synchronise rx; [2] is the previous synchronised value, so a start
  // bit needs a real falling edge and a line stuck low after a framing error
  // is not mistaken for a stream of new start bits.
  logic [2:0]       sync_q;
  logic             rx_s, rx_prev;
  rx_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shift_q, shift_d;
  logic             valid_q, valid_d, err_q, err_d;

  assign rx_s    = sync_q[1];
  assign rx_prev = sync_q[2];

  // NOTE: always_ff uses non-blocking assignments only, so every register
  // samples the pre-edge value of every other register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync_q  <= 3'b111;
      state_q <= RX_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      sync_q  <= {sync_q[1:0], rx};
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  // NOTE: every signal driven here gets a default first; a missing default on
  // any path would infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    bit_d   = bit_q;
    shift_d = shift_q;
    valid_d = 1'b0;
    err_d   = 1'b0;
    unique case (state_q)
      RX_IDLE: begin
        cnt_d = '0;
        if (rx_prev && !rx_s) state_d = RX_START;
      end
      RX_START: begin
        // Half a bit in: still low means a genuine start bit.
        if (cnt_q == HALF) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = rx_s ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (cnt_q == FULL) begin
          cnt_d   = '0;
          shift_d = {rx_s, shift_q[7:1]};
          bit_d   = bit_q + 1'b1;
          if (bit_q == 3'd7) state_d = RX_STOP;
        end
      end
      RX_STOP: begin
        if (cnt_q == FULL) begin
          valid_d = rx_s;
          err_d   = !rx_s;
          state_d = RX_IDLE;
        end
      end
      default: state_d = RX_IDLE;
    endcase
  end

  assign byte_valid = valid_q;
  assign byte_data  = shift_q;
  assign frame_err  = err_q;

endmodule

// File: rtl/programma_lader.sv
// -----------------------------------------------------------------------------
// programma_lader
// Serial program loader. Receives a frame {HEADER_BYTE, N, 5*N payload bytes}
// over UART and writes N 40-bit words (MSB first) to instruction memory at
// addresses 0..N-1 (N = 0 means 256). Holds the CPU halted during the load and
// pulses laden_klaar on success; errors set a sticky fout and keep the halt.
//   clock, reset_n : system clock, asynchronous active-low reset
//   rx             : UART receive line
//   mem            : instruction memory write port (programma_lader_if.master)
//   cpu_halt       : high while loading or after a failed load
//   laden_klaar    : one-cycle pulse on successful completion
//   fout           : sticky error flag, cleared by the next accepted header
// Build option: PROGRAMMA_CHECKSUM_EN adds a trailing XOR checksum byte.
// -----------------------------------------------------------------------------
module programma_lader
  import lader_pkg::*;
#(
  parameter int         CLKS_PER_BIT = 434,
  parameter int         TIMEOUT_CLKS = 50000000,
  parameter logic [7:0] HEADER_BYTE  = HEADER_BYTE_DEFAULT
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                rx,
  programma_lader_if.master   mem,
  output logic                cpu_halt,
  output logic                laden_klaar,
  output logic                fout
);

  localparam int TMO_W = $clog2(TIMEOUT_CLKS + 1);

  logic       rx_valid, rx_err;
  logic [7:0] rx_byte;

  uart_rx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clock      (clock),
    .reset_n    (reset_n),
    .rx         (rx),
    .byte_valid (rx_valid),
    .byte_data  (rx_byte),
    .frame_err  (rx_err)
  );

  lader_state_e     state_q, state_d;
  logic [15:0]      addr_q, addr_d;
  instr_word_t      word_q, word_d;
  logic [2:0]       byte_cnt_q, byte_cnt_d;
  logic [8:0]       left_q, left_d;        // words still to be written
  logic             halt_q, halt_d, fout_q, fout_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             timeout, fail, we_c, klaar_c;
`ifdef PROGRAMMA_CHECKSUM_EN
  logic [7:0]       xor_q, xor_d;
`endif

  assign timeout = (tmo_q == TMO_W'(TIMEOUT_CLKS));
  assign fail    = rx_err || timeout;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      // NOTE: the assembly register is a plain flop bank, not a memory, and
      // it drives mem_wdata directly, so it is reset to give a defined 0.
      word_q     <= '0;
      byte_cnt_q <= '0;
      left_q     <= '0;
      halt_q     <= 1'b0;
      fout_q     <= 1'b0;
      tmo_q      <= '0;
`ifdef PROGRAMMA_CHECKSUM_EN
      xor_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      word_q     <= word_d;
      byte_cnt_q <= byte_cnt_d;
      left_q     <= left_d;
      halt_q     <= halt_d;
      fout_q     <= fout_d;
      tmo_q      <= tmo_d;
`ifdef PROGRAMMA_CHECKSUM_EN
      xor_q      <= xor_d;
`endif
    end
  end

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    word_d     = word_q;
    byte_cnt_d = byte_cnt_q;
    left_d     = left_q;
    halt_d     = halt_q;
    fout_d     = fout_q;
    we_c       = 1'b0;
    klaar_c    = 1'b0;
`ifdef PROGRAMMA_CHECKSUM_EN
    xor_d      = xor_q;
`endif
    // Inter-byte watchdog: restarts on each received byte, idle outside a frame,
    // saturates so it cannot wrap back below the limit.
    if (state_q == ST_IDLE || rx_valid) tmo_d = '0;
    else if (!timeout)                  tmo_d = tmo_q + 1'b1;
    else                                tmo_d = tmo_q;

    unique case (state_q)
      ST_IDLE: begin
        if (rx_valid && rx_byte == HEADER_BYTE) begin
          state_d = ST_COUNT;
          halt_d  = 1'b1;
          fout_d  = 1'b0;
          addr_d  = '0;
`ifdef PROGRAMMA_CHECKSUM_EN
          xor_d   = '0;
`endif
        end
      end
      ST_COUNT: begin
        if (fail) begin
          fout_d  = 1'b1;
          state_d = ST_IDLE;
        end else if (rx_valid) begin
          left_d     = words_in_frame(rx_byte);
          byte_cnt_d = '0;
          state_d    = ST_DATA;
        end
      end
      ST_DATA: begin
        if (fail) begin
          fout_d  = 1'b1;
          state_d = ST_IDLE;
        end else if (rx_valid) begin
          // Header-valued bytes land here as ordinary payload.
          word_d = {word_q[WORD_W-9:0], rx_byte};
`ifdef PROGRAMMA_CHECKSUM_EN
          xor_d  = xor_q ^ rx_byte;
`endif
          if (byte_cnt_q == 3'(WORD_BYTES - 1)) begin
            byte_cnt_d = '0;
            state_d    = ST_WRITE;
          end else begin
            byte_cnt_d = byte_cnt_q + 1'b1;
          end
        end
      end
      ST_WRITE: begin
        we_c   = 1'b1;
        addr_d = addr_q + 1'b1;
        left_d = left_q - 1'b1;
        if (left_q == 9'd1) begin
`ifdef PROGRAMMA_CHECKSUM_EN
          state_d = ST_CHECK;
`else
          state_d = ST_DONE;
          halt_d  = 1'b0;
`endif
        end else begin
          state_d = ST_DATA;
        end
      end
`ifdef PROGRAMMA_CHECKSUM_EN
      ST_CHECK: begin
        if (fail) begin
          fout_d  = 1'b1;
          state_d = ST_IDLE;
        end else if (rx_valid) begin
          if (rx_byte == xor_q) begin
            state_d = ST_DONE;
            halt_d  = 1'b0;
          end else begin
            fout_d  = 1'b1;
            state_d = ST_IDLE;
          end
        end
      end
`endif
      ST_DONE: begin
        klaar_c = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign mem.mem_we    = we_c;
  assign mem.mem_addr  = addr_q;
  assign mem.mem_wdata = word_q;
  assign cpu_halt      = halt_q;
  assign laden_klaar   = klaar_c;
  assign fout          = fout_q;

endmodule
